rom_seq_reader: RTL and testbench

Sequencer that sits directly upstream of the team's combinational address-to-data lookup ROM. It drives the ROM address, walks a programmed run of consecutive addresses with wrap-around, and registers each returned word. Each word is presented downstream on a valid/ready stream, and the block pulses `done` when the run is finished.

---
 rtl/rom_seq_reader.sv | 189 ++++++++++++++++++
 tb/tb_rom_seq_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_seq_reader.sv
`default_nettype none
// ============================================================================
//  Module   : rom_seq_reader
//  Purpose  : Sequencer in front of a combinational address-to-data ROM.
//             Walks a programmed run of consecutive addresses (wrapping at
//             2^ADDR_WIDTH), registers each returned word and offers it on a
//             valid/ready stream. Pulses done for one cycle when the run ends.
//
//  Parameters
//    ADDR_WIDTH   ROM address width
//    DATA_WIDTH   ROM data width
//
//  Ports
//    clk          clock, rising edge
//    rst          asynchronous active-high reset
//    start        run request, sampled only while idle
//    start_addr   first address of the run
//    len          number of words to read (0 .. 2^(ADDR_WIDTH+1)-1)
//    addr         registered ROM address
//    rom_data     combinational ROM output for addr
//    out_data     captured word
//    out_valid    out_data is valid
//    out_ready    downstream accepts the word
//    busy         high whenever the sequencer is not idle
//    done         one-cycle pulse at end of run
//    out_parity   even parity of out_data (only with SEQ_PARITY_EN)
//
//  Build option
//    SEQ_PARITY_EN  when defined, adds the out_parity output and its register
//
//  Revision : 1.0  initial release
// ============================================================================
module rom_seq_reader #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
`ifdef SEQ_PARITY_EN
   ,
   output logic                  out_parity
`endif
);

   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   c_REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH-1:0]   w_addr_nxt;
   // Words still to be fetched after the one currently in flight.
   logic [ADDR_WIDTH:0]     r_remaining;
   logic [ADDR_WIDTH:0]     w_remaining_nxt;
   logic [DATA_WIDTH-1:0]   r_out_data;
   logic [DATA_WIDTH-1:0]   w_out_data_nxt;
   logic                    r_out_valid;
   logic                    w_out_valid_nxt;
   logic                    w_handshake;

`ifdef SEQ_PARITY_EN
   logic                    r_parity;
   logic                    w_parity_nxt;
`endif

   // A transfer completes only while a word is actually being offered.
   assign w_handshake = r_out_valid & out_ready;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_remaining <= w_remaining_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

`ifdef SEQ_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else begin
         r_parity <= w_parity_nxt;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Next-state and next-datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_remaining_nxt = r_remaining;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
`ifdef SEQ_PARITY_EN
      w_parity_nxt    = r_parity;
`endif

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  w_addr_nxt      = start_addr;
                  w_remaining_nxt = len;
                  w_state_nxt     = ST_FETCH;
               end else begin
                  // Empty run: report completion without producing data.
                  w_state_nxt = ST_DONE;
               end
            end
         end

         ST_FETCH: begin
            // addr has been stable for this whole cycle, so rom_data is settled.
            w_out_data_nxt  = rom_data;
            w_remaining_nxt = r_remaining - c_REM_ONE;
            w_out_valid_nxt = 1'b1;
`ifdef SEQ_PARITY_EN
            w_parity_nxt    = ^rom_data;
`endif
            w_state_nxt     = ST_HOLD;
         end

         ST_HOLD: begin
            if (w_handshake) begin
               w_out_valid_nxt = 1'b0;
               if (r_remaining == '0) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  // Natural overflow gives the wrap back to address 0.
                  w_addr_nxt  = r_addr + c_ADDR_ONE;
                  w_state_nxt = ST_FETCH;
               end
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign addr      = r_addr;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
`ifdef SEQ_PARITY_EN
   assign out_parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_seq_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_seq_reader
//  Purpose  : Self-checking bench for rom_seq_reader. Stimulus pushes the
//             hand-computed expected words into a scoreboard queue; a monitor
//             pops and compares on every stream handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rom_seq_reader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] start_addr;
   logic [2:0] len;
   logic [1:0] addr;
   logic [2:0] rom_data;
   logic [2:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;
`ifdef SEQ_PARITY_EN
   logic       out_parity;
`endif

   rom_seq_reader #(
      .ADDR_WIDTH(2),
      .DATA_WIDTH(3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .addr       (addr),
      .rom_data   (rom_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
`ifdef SEQ_PARITY_EN
      ,
      .out_parity (out_parity)
`endif
   );

   // Combinational ROM model
   always_comb begin
      case (addr)
         2'd0:    rom_data = 3'b011;
         2'd1:    rom_data = 3'b110;
         2'd2:    rom_data = 3'b100;
         default: rom_data = 3'b010;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] a;
      logic [2:0] d;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   words    = 0;
   int   dones    = 0;
   int   rises    = 0;
   int   last_hs  = -1;
   logic prev_valid = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   task automatic push(input logic [1:0] a, input logic [2:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      sb.push_back(e);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: samples on the falling edge, away from the active edge.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         prev_valid = 1'b0;
         last_hs    = -1;
      end else begin
         if (out_valid && !prev_valid) begin
            rises++;
            if (last_hs >= 0) chk("valid_gap", cyc - last_hs, 2);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_word", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("word_data", int'(out_data), int'(e.d));
               chk("word_addr", int'(addr), int'(e.a));
`ifdef SEQ_PARITY_EN
               chk("word_parity", int'(out_parity), int'(^e.d));
`endif
            end
            words++;
            last_hs = cyc;
         end
         if (done) begin
            dones++;
            if (last_hs >= 0) chk("done_after_last", cyc - last_hs, 1);
         end
         if (!busy) last_hs = -1;
         prev_valid = out_valid;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic start_run(input logic [1:0] sa, input logic [2:0] ln);
      @(posedge clk); #1;
      start      = 1'b1;
      start_addr = sa;
      len        = ln;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_end(input int d0, input int w0, input int exp_words);
      for (int i = 0; i < 200 && dones == d0; i++) begin
         @(negedge clk); #1;
      end
      chk("run_done_count", dones - d0, 1);
      chk("run_word_count", words - w0, exp_words);
      chk("scoreboard_empty", sb.size(), 0);
      @(negedge clk); #1;
      chk("done_one_cycle", int'(done), 0);
      chk("idle_after_done", int'(busy), 0);
   endtask

   task automatic wait_valid();
      int i;
      for (i = 0; i < 50 && !out_valid; i++) begin
         @(negedge clk); #1;
      end
      chk("valid_timeout", int'(out_valid), 1);
   endtask

   initial begin
      int d0, w0, r0;
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      len        = '0;
      out_ready  = 1'b1;

      // Reset state
      @(negedge clk); #1;
      chk("rst_addr", int'(addr), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic run
      push(2'd0, 3'b011); push(2'd1, 3'b110); push(2'd2, 3'b100); push(2'd3, 3'b010);
      d0 = dones; w0 = words;
      start_run(2'd0, 3'd4);
      wait_end(d0, w0, 4);

      // Wrap-around
      push(2'd3, 3'b010); push(2'd0, 3'b011); push(2'd1, 3'b110);
      d0 = dones; w0 = words;
      start_run(2'd3, 3'd3);
      wait_end(d0, w0, 3);

      // Backpressure on the first word
      out_ready = 1'b0;
      push(2'd0, 3'b011); push(2'd1, 3'b110);
      d0 = dones; w0 = words;
      start_run(2'd0, 3'd2);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_data", int'(out_data), 3);
      end
      chk("bp_no_word", words - w0, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_end(d0, w0, 2);

      // len = 0
      d0 = dones; r0 = rises;
      start_run(2'd1, 3'd0);
      @(negedge clk); #1;
      chk("len0_done", int'(done), 1);
      @(negedge clk); #1;
      chk("len0_done_cleared", int'(done), 0);
      chk("len0_idle", int'(busy), 0);
      chk("len0_done_count", dones - d0, 1);
      chk("len0_no_valid", rises - r0, 0);

      // start pulsed while busy is ignored
      push(2'd0, 3'b011); push(2'd1, 3'b110); push(2'd2, 3'b100); push(2'd3, 3'b010);
      d0 = dones; w0 = words;
      start_run(2'd0, 3'd4);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; start_addr = 2'd2; len = 3'd1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_end(d0, w0, 4);
      repeat (3) begin
         @(negedge clk); #1;
         chk("no_queued_start", int'(busy), 0);
      end

      // Reset mid-HOLD
      out_ready = 1'b0;
      d0 = dones;
      start_run(2'd1, 3'd4);
      wait_valid();
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_addr", int'(addr), 0);
      chk("mid_rst_data", int'(out_data), 0);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
`ifdef SEQ_PARITY_EN
      chk("mid_rst_parity", int'(out_parity), 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("post_rst_no_done", dones - d0, 0);
      chk("post_rst_idle", int'(busy), 0);

      // Fresh run after reset
      push(2'd2, 3'b100); push(2'd3, 3'b010);
      d0 = dones; w0 = words;
      start_run(2'd2, 3'd2);
      wait_end(d0, w0, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
